// File: rtl/accumulate_unit.sv
// rtl/accumulate_unit.sv - programmable-length accumulator with valid/ready input and output
//
// Accumulates num_terms IN_W-bit terms into an OUT_W-bit sum (signed or
// unsigned, saturating or wrapping), then presents the sum on out_valid/out_ready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, num_terms        job request (sampled in IDLE only) and term count
//   in_valid/in_ready/in_data   input term stream
//   out_valid/out_ready/out_sum result handshake and value
//   overflow                sticky range-exceeded flag for the current job
//   busy                    high whenever not IDLE
module accumulate_unit #(
    parameter int IN_W   = 5,
    parameter int OUT_W  = 10,
    parameter int CNT_W  = 6,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_sum,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_num;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_sum;
    logic               r_overflow;

    logic [OUT_W:0]     w_ext;
    logic [OUT_W:0]     w_sum;
    logic               w_range_err;
    logic [OUT_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_xfer;
    logic               w_last;

    localparam logic [OUT_W-1:0] U_MAX = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // One guard bit above the accumulator: unsigned overflow shows as a carry
    // into it, signed overflow as a disagreement between it and the MSB.
    always_comb begin
        w_ext       = {{(OUT_W+1-IN_W){1'b0}}, in_data};
        w_sum       = {1'b0, r_acc} + w_ext;
        w_range_err = w_sum[OUT_W];
        if (SIGNED != 0) begin
            w_ext       = {{(OUT_W+1-IN_W){in_data[IN_W-1]}}, in_data};
            w_sum       = {r_acc[OUT_W-1], r_acc} + w_ext;
            w_range_err = w_sum[OUT_W] ^ w_sum[OUT_W-1];
        end
        w_acc_next = w_sum[OUT_W-1:0];
        if (w_range_err && (SAT != 0)) begin
            if (SIGNED != 0) begin
                w_acc_next = w_sum[OUT_W] ? S_MIN : S_MAX;
            end else begin
                w_acc_next = U_MAX;
            end
        end
    end

    assign w_count_next = r_count + CNT_W'(1);
    assign w_xfer       = in_valid & r_in_ready;
    assign w_last       = (w_count_next == r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_num       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_num      <= num_terms;
                        r_overflow <= 1'b0;
                        if (num_terms == '0) begin
                            r_out_sum   <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc   <= w_acc_next;
                        r_count <= w_count_next;
                        if (w_range_err) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last) begin
                            r_in_ready  <= 1'b0;
                            r_out_sum   <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_accumulate_unit.sv
// tb/tb_accumulate_unit.sv - directed vector bench for accumulate_unit
module tb_accumulate_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_v;
    logic [5:0] num_terms;
    logic       in_valid;
    logic [4:0] in_data;
    logic       out_ready;

    logic [3:0] rdy_v, ov_v, of_v, bz_v;
    logic [9:0] sum0;
    logic [7:0] sum1, sum2;
    logic [5:0] sum3;

    int n_cmp;
    int n_bad;

    // u0: unsigned sat OUT_W=10; u1: unsigned sat OUT_W=8;
    // u2: unsigned wrap OUT_W=8; u3: signed sat OUT_W=6
    accumulate_unit #(.IN_W(5), .OUT_W(10), .CNT_W(6), .SIGNED(0), .SAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(rdy_v[0]), .in_data(in_data),
        .out_valid(ov_v[0]), .out_ready(out_ready), .out_sum(sum0),
        .overflow(of_v[0]), .busy(bz_v[0]));
    accumulate_unit #(.IN_W(5), .OUT_W(8), .CNT_W(6), .SIGNED(0), .SAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(rdy_v[1]), .in_data(in_data),
        .out_valid(ov_v[1]), .out_ready(out_ready), .out_sum(sum1),
        .overflow(of_v[1]), .busy(bz_v[1]));
    accumulate_unit #(.IN_W(5), .OUT_W(8), .CNT_W(6), .SIGNED(0), .SAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(rdy_v[2]), .in_data(in_data),
        .out_valid(ov_v[2]), .out_ready(out_ready), .out_sum(sum2),
        .overflow(of_v[2]), .busy(bz_v[2]));
    accumulate_unit #(.IN_W(5), .OUT_W(6), .CNT_W(6), .SIGNED(1), .SAT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(rdy_v[3]), .in_data(in_data),
        .out_valid(ov_v[3]), .out_ready(out_ready), .out_sum(sum3),
        .overflow(of_v[3]), .busy(bz_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        int         n;
        int         t [10];
        logic [9:0] es;
        logic       eo;
    } vec_t;

    vec_t vt [9];

    function automatic logic [9:0] get_sum(input int inst);
        case (inst)
            0:       return sum0;
            1:       return {2'b00, sum1};
            2:       return {2'b00, sum2};
            default: return {4'b0000, sum3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int inst, input int n);
        start_v[inst] = 1'b1;
        num_terms     = n[5:0];
        tick();
        start_v = '0;
    endtask

    task automatic send_term(input int inst, input int d, input int gap);
        bit got;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d[4:0];
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy_v[inst]) begin
                got = 1;
                break;
            end
        end
        if (!got) check("term_accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input int inst, input logic [9:0] es, input logic eo, input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(ov_v[inst]), 1);
        check({tag, "_in_ready"},  32'(rdy_v[inst]), 0);
        check({tag, "_sum"},       32'(get_sum(inst)), 32'(es));
        check({tag, "_overflow"},  32'(of_v[inst]), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"},  32'(bz_v[inst]), 0);
        check({tag, "_valid_after"}, 32'(ov_v[inst]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start_v   = '0;
        num_terms = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vt[0] = '{1, 10, '{31,31,31,31,31,31,31,31,31,31}, 10'd255, 1'b1};
        vt[1] = '{2, 10, '{31,31,31,31,31,31,31,31,31,31}, 10'd54,  1'b1};
        vt[2] = '{3, 3,  '{16,16,16,0,0,0,0,0,0,0},        10'd32,  1'b1};
        vt[3] = '{3, 3,  '{15,29,2,0,0,0,0,0,0,0},         10'd14,  1'b0};
        vt[4] = '{3, 3,  '{15,15,15,0,0,0,0,0,0,0},        10'd31,  1'b1};
        vt[5] = '{3, 2,  '{16,31,0,0,0,0,0,0,0,0},         10'd47,  1'b0};
        vt[6] = '{0, 3,  '{1,2,3,0,0,0,0,0,0,0},           10'd6,   1'b0};
        vt[7] = '{0, 1,  '{0,0,0,0,0,0,0,0,0,0},           10'd0,   1'b0};
        vt[8] = '{1, 3,  '{10,20,30,0,0,0,0,0,0,0},        10'd60,  1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(rdy_v[0]), 0);
        check("rst_out_valid", 32'(ov_v[0]), 0);
        check("rst_out_sum",   32'(sum0), 0);
        check("rst_overflow",  32'(of_v[0]), 0);
        check("rst_busy",      32'(bz_v[0]), 0);
        rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            start_job(vt[i].inst, vt[i].n);
            for (int j = 0; j < vt[i].n; j++) send_term(vt[i].inst, vt[i].t[j], 0);
            collect(vt[i].inst, vt[i].es, vt[i].eo, $sformatf("vec%0d", i));
        end

        // Zero terms: result one cycle after start, in_ready never raised
        start_job(0, 0);
        collect(0, 10'd0, 1'b0, "zero_terms");

        // Gapped input, extra term refused, then output backpressure
        start_job(0, 4);
        for (int j = 0; j < 4; j++) send_term(0, 31, 2);
        in_valid = 1'b1;
        in_data  = 5'd31;
        @(negedge clk);
        check("gap_latency_valid", 32'(ov_v[0]), 1);
        check("gap_sum",           32'(sum0), 124);
        check("gap_no_fifth",      32'(rdy_v[0]), 0);
        start_v[0] = 1'b1;
        num_terms  = 6'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", c), 32'(ov_v[0]), 1);
            check($sformatf("bp%0d_sum", c),   32'(sum0), 124);
            check($sformatf("bp%0d_busy", c),  32'(bz_v[0]), 1);
            check($sformatf("bp%0d_ready", c), 32'(rdy_v[0]), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready  = 1'b0;
        start_v    = '0;
        in_valid   = 1'b0;
        @(negedge clk);
        check("bp_release_busy",  32'(bz_v[0]), 0);
        check("bp_release_valid", 32'(ov_v[0]), 0);
        check("bp_release_sum",   32'(sum0), 124);

        // Reset in the middle of a job acts before any clock edge
        start_job(0, 5);
        for (int j = 0; j < 3; j++) send_term(0, 7, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(rdy_v[0]), 0);
        check("midrst_busy",      32'(bz_v[0]), 0);
        check("midrst_out_valid", 32'(ov_v[0]), 0);
        check("midrst_out_sum",   32'(sum0), 0);
        check("midrst_overflow",  32'(of_v[0]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(0, 2);
        send_term(0, 4, 0);
        send_term(0, 5, 0);
        collect(0, 10'd9, 1'b0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
